// File: rtl/serial_bus_arbiter_if.sv
// Serial bus arbiter interface: initiator requests, target split/resume
// pulses, and the registered grant/status bundle. master = arbiter side.
interface serial_bus_arbiter_if #(
  parameter int N_INIT = 2
);
  localparam int W = $clog2(N_INIT);

  logic [N_INIT-1:0] req;
  logic              split;
  logic              split_resume;
  logic [N_INIT-1:0] grant;
  logic [W-1:0]      owner_id;
  logic              bus_busy;
  logic              split_pending;
  logic [W-1:0]      split_owner;
  logic              timeout_pulse;

  modport master (
    input  req, split, split_resume,
    output grant, owner_id, bus_busy,
    output split_pending, split_owner, timeout_pulse
  );

  modport slave (
    output req, split, split_resume,
    input  grant, owner_id, bus_busy,
    input  split_pending, split_owner, timeout_pulse
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with one parked split and optional
// grant watchdog (define ARB_TIMEOUT_EN). Ports: clk, rst_n, bus (master).
module serial_bus_arbiter #(
  parameter int N_INIT   = 2,
  parameter int HOLD_MAX = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_bus_arbiter_if.master bus
);

  localparam int W = $clog2(N_INIT);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOVER
  } state_t;

  state_t            state_q, state_d;
  logic [N_INIT-1:0] grant_q, grant_d;
  logic [W-1:0]      owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      last_q, last_d;
  logic              pend_q, pend_d;
  logic [W-1:0]      spown_q, spown_d;
  logic              seen_q, seen_d;
  logic              tmo_q, tmo_d;

  logic              pick_ok;
  logic [W-1:0]      pick;
  logic [W-1:0]      cand;
  int                j;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_exp;
  assign hold_exp = (cnt_q == CW'(HOLD_MAX - 1));
`else
  logic unused_hold;
  assign unused_hold = |HOLD_MAX;
`endif

  // Round-robin pick starting after last_q; a parked initiator is skipped.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    cand    = '0;
    j       = 0;
    for (int k = 1; k <= N_INIT; k++) begin
      j = int'(last_q) + k;
      if (j >= N_INIT) j = j - N_INIT;
      cand = j[W-1:0];
      if (!pick_ok && bus.req[cand] &&
          !(pend_q && cand == spown_q)) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    owner_d = owner_q;
    busy_d  = 1'b0;
    last_d  = last_q;
    pend_d  = pend_q;
    spown_d = spown_q;
    seen_d  = seen_q;
    tmo_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    // A resume outside IDLE is remembered for the next arbitration.
    if (state_q != IDLE && pend_q && bus.split_resume)
      seen_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pend_q && (bus.split_resume || seen_q)) begin
          pend_d = 1'b0;
          seen_d = 1'b0;
          if (bus.req[spown_q]) begin
            grant_d[spown_q] = 1'b1;
            owner_d = spown_q;
            busy_d  = 1'b1;
            state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else if (pick_ok) begin
          grant_d[pick] = 1'b1;
          owner_d = pick;
          busy_d  = 1'b1;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        grant_d = grant_q;
        busy_d  = 1'b1;
        // Split beats release; a second split while parked is ignored.
        if (bus.split && !pend_q) begin
          pend_d  = 1'b1;
          spown_d = owner_q;
          last_d  = owner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = HANDOVER;
        end else if (!bus.req[owner_q]) begin
          last_d  = owner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = HANDOVER;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_exp) begin
          last_d  = owner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = HANDOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      HANDOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= W'(N_INIT - 1);
      pend_q  <= 1'b0;
      spown_q <= '0;
      seen_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      spown_q <= spown_d;
      seen_q  <= seen_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.grant         = grant_q;
  assign bus.owner_id      = owner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.split_pending = pend_q;
  assign bus.split_owner   = spown_q;
  assign bus.timeout_pulse = tmo_q;

endmodule
